// File: rtl/dmem_rf_sequencer_pkg.sv
// Shared types and default widths for the data-memory / register-file sequencer.
package dmem_seq_pkg;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned RW_DEF = 4;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StStBeat,
      StLdAddr,
      StLdWait,
      StLdWb,
      StFinish
   } state_e;

endpackage

// File: rtl/dmem_rf_sequencer_burst_addr_gen.sv
// Beat counter and base registers; addresses are presented for the beat about to be registered.
module burst_addr_gen #(
   parameter int unsigned AW = 8,
   parameter int unsigned RW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_load,
   input  logic          i_adv,
   input  logic [AW-1:0] i_d_base,
   input  logic [RW-1:0] i_rf_base,
   input  logic [3:0]    i_len,
   output logic [AW-1:0] o_d_addr,
   output logic [RW-1:0] o_rf_addr,
   output logic          o_last
);

   logic [AW-1:0] r_d_base;
   logic [RW-1:0] r_rf_base;
   logic [3:0]    r_len;
   logic [3:0]    r_idx;
   logic [3:0]    w_idx_nxt;
   logic [AW-1:0] w_d_base;
   logic [RW-1:0] w_rf_base;

   always_comb begin
      w_idx_nxt = r_idx;
      if (i_load) begin
         w_idx_nxt = '0;
      end else if (i_adv) begin
         w_idx_nxt = r_idx + 4'd1;
      end
   end

   // On acceptance the bases bypass their registers so the first beat is ready at once.
   assign w_d_base  = i_load ? i_d_base : r_d_base;
   assign w_rf_base = i_load ? i_rf_base : r_rf_base;
   assign o_d_addr  = w_d_base + AW'(w_idx_nxt);
   assign o_rf_addr = w_rf_base + RW'(w_idx_nxt);
   assign o_last    = (r_idx == r_len);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_d_base  <= '0;
         r_rf_base <= '0;
         r_len     <= '0;
         r_idx     <= '0;
      end else begin
         if (i_load) begin
            r_d_base  <= i_d_base;
            r_rf_base <= i_rf_base;
            r_len     <= i_len;
         end
         r_idx <= w_idx_nxt;
      end
   end

endmodule

// File: rtl/dmem_rf_sequencer.sv
// Burst sequencer driving data-memory and register-file control pins; all outputs registered.
module dmem_rf_sequencer
   import dmem_seq_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW     = AW_DEF,
   parameter int unsigned RW     = RW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [AW-1:0] cmd_d_addr,
   input  logic [RW-1:0] cmd_rf_addr,
   input  logic [3:0]    cmd_len,
   output logic [AW-1:0] D_addr,
   output logic          D_W_en,
   output logic          RF_W_en,
   output logic [RW-1:0] RF_W_addr,
   output logic [RW-1:0] RF_Ra_addr,
   output logic          busy,
   output logic          done
);

   localparam int unsigned WaitMax  = (RD_LAT > 1) ? RD_LAT - 2 : 0;
   localparam logic [1:0]  WaitLast = 2'(WaitMax);

   state_e        r_state;
   logic [1:0]    r_wait;
   logic          r_ready;
   logic [AW-1:0] r_d_addr;
   logic          r_d_we;
   logic          r_rf_we;
   logic [RW-1:0] r_rf_wa;
   logic [RW-1:0] r_rf_ra;
   logic          r_busy;
   logic          r_done;

   logic          w_accept;
   logic          w_adv;
   logic          w_last;
   logic [AW-1:0] w_d_addr;
   logic [RW-1:0] w_rf_addr;

   assign w_accept = (r_state == StIdle) && cmd_valid && r_ready;
   assign w_adv    = ((r_state == StStBeat) || (r_state == StLdWb)) && !w_last;

   burst_addr_gen #(
      .AW(AW),
      .RW(RW)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_accept),
      .i_adv    (w_adv),
      .i_d_base (cmd_d_addr),
      .i_rf_base(cmd_rf_addr),
      .i_len    (cmd_len),
      .o_d_addr (w_d_addr),
      .o_rf_addr(w_rf_addr),
      .o_last   (w_last)
   );

   // Output registers are loaded with the values belonging to the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_wait   <= '0;
         r_ready  <= 1'b0;
         r_d_addr <= '0;
         r_d_we   <= 1'b0;
         r_rf_we  <= 1'b0;
         r_rf_wa  <= '0;
         r_rf_ra  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_d_we  <= 1'b0;
         r_rf_we <= 1'b0;
         unique case (r_state)
            StIdle: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_d_addr <= w_d_addr;
                  if (op_e'(cmd_op) == OP_STORE) begin
                     r_state <= StStBeat;
                     r_d_we  <= 1'b1;
                     r_rf_ra <= w_rf_addr;
                  end else begin
                     r_state <= StLdAddr;
                  end
               end
            end
            StStBeat: begin
               if (w_last) begin
                  r_state  <= StFinish;
                  r_done   <= 1'b1;
                  r_d_addr <= '0;
                  r_rf_ra  <= '0;
               end else begin
                  r_d_we   <= 1'b1;
                  r_d_addr <= w_d_addr;
                  r_rf_ra  <= w_rf_addr;
               end
            end
            StLdAddr: begin
               if (RD_LAT > 1) begin
                  r_state <= StLdWait;
                  r_wait  <= '0;
               end else begin
                  r_state <= StLdWb;
                  r_rf_we <= 1'b1;
                  r_rf_wa <= w_rf_addr;
               end
            end
            StLdWait: begin
               if (r_wait == WaitLast) begin
                  r_state <= StLdWb;
                  r_rf_we <= 1'b1;
                  r_rf_wa <= w_rf_addr;
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            StLdWb: begin
               r_rf_wa <= '0;
               if (w_last) begin
                  r_state  <= StFinish;
                  r_done   <= 1'b1;
                  r_d_addr <= '0;
               end else begin
                  r_state  <= StLdAddr;
                  r_d_addr <= w_d_addr;
               end
            end
            StFinish: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign cmd_ready  = r_ready;
   assign D_addr     = r_d_addr;
   assign D_W_en     = r_d_we;
   assign RF_W_en    = r_rf_we;
   assign RF_W_addr  = r_rf_wa;
   assign RF_Ra_addr = r_rf_ra;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_dmem_rf_sequencer.sv
// Bench: two sequencers (RD_LAT 1 and 3) against a per-cycle trace model plus directed literal checks.
module tb_dmem_rf_sequencer;

   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       done;
      logic       dwe;
      logic       rfwe;
      logic [7:0] daddr;
      logic [3:0] rfwa;
      logic [3:0] rfra;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_op;
   logic [7:0] cmd_d_addr;
   logic [3:0] cmd_rf_addr;
   logic [3:0] cmd_len;

   logic       rdy [2];
   logic       bsy [2];
   logic       dn  [2];
   logic       dwe [2];
   logic       rwe [2];
   logic [7:0] da  [2];
   logic [3:0] rwa [2];
   logic [3:0] rra [2];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int acc_cyc [2];
   int done_cyc [2];
   int done_cnt [2];
   logic mdl_on = 1'b0;

   always #5 clk = ~clk;

   dmem_rf_sequencer #(.RD_LAT(1), .AW(8), .RW(4)) u_dut_l1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]), .cmd_op(cmd_op),
      .cmd_d_addr(cmd_d_addr), .cmd_rf_addr(cmd_rf_addr), .cmd_len(cmd_len), .D_addr(da[0]),
      .D_W_en(dwe[0]), .RF_W_en(rwe[0]), .RF_W_addr(rwa[0]), .RF_Ra_addr(rra[0]),
      .busy(bsy[0]), .done(dn[0])
   );

   dmem_rf_sequencer #(.RD_LAT(3), .AW(8), .RW(4)) u_dut_l3 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]), .cmd_op(cmd_op),
      .cmd_d_addr(cmd_d_addr), .cmd_rf_addr(cmd_rf_addr), .cmd_len(cmd_len), .D_addr(da[1]),
      .D_W_en(dwe[1]), .RF_W_en(rwe[1]), .RF_W_addr(rwa[1]), .RF_Ra_addr(rra[1]),
      .busy(bsy[1]), .done(dn[1])
   );

   task automatic chk(input string name, input int inst, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (inst %0d, cycle %0d): got 0x%0h, expected 0x%0h",
                  name, inst, cyc, got, exp);
      end
   endtask

   // Datapath beside the RD_LAT=1 instance: sync-read memory, async-read register file.
   logic [15:0] mem [256];
   logic [15:0] rf  [16];
   logic [15:0] q;
   logic        pl_mem = 1'b0, pl_rf = 1'b0;
   logic [7:0]  pl_a = '0;
   logic [15:0] pl_d = '0;

   always @(posedge clk) begin
      q <= mem[da[0]];
      if (dwe[0]) mem[da[0]] <= rf[rra[0]];
      if (rwe[0]) rf[rwa[0]] <= q;
      if (pl_mem) mem[pl_a] <= pl_d;
      if (pl_rf) rf[pl_a[3:0]] <= pl_d;
   end

   task automatic preload(input logic is_rf, input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_mem = !is_rf; pl_rf = is_rf; pl_a = a; pl_d = d;
      @(negedge clk);
      pl_mem = 1'b0; pl_rf = 1'b0;
   endtask

   // Model: each accepted command expands into the list of output vectors it must produce.
   exp_t mq0[$];
   exp_t mq1[$];
   exp_t cur [2];

   task automatic qpush(input int inst, input exp_t e);
      if (inst == 0) mq0.push_back(e);
      else mq1.push_back(e);
   endtask

   task automatic build(input int inst, input int lat);
      exp_t e;
      for (int k = 0; k <= int'(cmd_len); k++) begin
         if (cmd_op) begin
            e = '0; e.busy = 1'b1; e.dwe = 1'b1;
            e.daddr = 8'(cmd_d_addr + k); e.rfra = 4'(cmd_rf_addr + k);
            qpush(inst, e);
         end else begin
            for (int w = 0; w < lat; w++) begin
               e = '0; e.busy = 1'b1; e.daddr = 8'(cmd_d_addr + k);
               qpush(inst, e);
            end
            e = '0; e.busy = 1'b1; e.daddr = 8'(cmd_d_addr + k);
            e.rfwe = 1'b1; e.rfwa = 4'(cmd_rf_addr + k);
            qpush(inst, e);
         end
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      qpush(inst, e);
   endtask

   task automatic model_step(input int inst, input int lat);
      exp_t e;
      exp_t idle_v;
      idle_v = '0;
      idle_v.ready = 1'b1;
      if (reset) begin
         if (inst == 0) mq0.delete(); else mq1.delete();
         e = '0;
      end else begin
         if (cur[inst].ready && cmd_valid) build(inst, lat);
         if (inst == 0) e = (mq0.size() != 0) ? mq0.pop_front() : idle_v;
         else e = (mq1.size() != 0) ? mq1.pop_front() : idle_v;
      end
      cur[inst] = e;
   endtask

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!reset && rdy[i] && cmd_valid) acc_cyc[i] = cyc;
      end
      model_step(0, 1);
      model_step(1, 3);
      mdl_on = 1'b1;
   end

   // Logs from the DUT ports, used by the hand-computed checks.
   logic [7:0] wlog_d[$];
   logic [3:0] wlog_r[$];
   logic [7:0] slog_a[$];
   int         slog_c[$];
   int         wb3[$];

   always @(negedge clk) begin
      if (mdl_on) begin
         for (int i = 0; i < 2; i++) begin
            chk("outputs_vs_model", i, 32'({rdy[i], bsy[i], dn[i], dwe[i], rwe[i], da[i],
                rwa[i], rra[i]}), 32'(cur[i]));
            if (dn[i]) begin
               done_cnt[i]++;
               done_cyc[i] = cyc;
            end
         end
         if (rwe[0]) begin
            wlog_d.push_back(da[0]);
            wlog_r.push_back(rwa[0]);
         end
         if (dwe[0]) begin
            slog_a.push_back(da[0]);
            slog_c.push_back(cyc);
         end
         if (rwe[1]) wb3.push_back(cyc - acc_cyc[1] + 1);
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (!(rdy[0] && rdy[1]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!(rdy[0] && rdy[1])) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout (cycle %0d): sequencers still busy after %0d cycles", cyc, n);
      end
   endtask

   task automatic send(input logic op, input logic [7:0] d, input logic [3:0] r,
                       input logic [3:0] len);
      @(negedge clk);
      cmd_op = op; cmd_d_addr = d; cmd_rf_addr = r; cmd_len = len; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   function automatic void clear_logs();
      wlog_d.delete(); wlog_r.delete(); slog_a.delete(); slog_c.delete(); wb3.delete();
   endfunction

   initial begin
      int d0;
      int done_edge;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
      cmd_d_addr = '0; cmd_rf_addr = '0; cmd_len = '0;
      for (int i = 0; i < 2; i++) begin
         acc_cyc[i] = 0; done_cyc[i] = 0; done_cnt[i] = 0;
      end

      // Reset values, then cmd_ready one cycle after release.
      repeat (3) @(negedge clk);
      chk("reset_ready", 0, 32'(rdy[0]), 0);
      chk("reset_busy", 1, 32'(bsy[1]), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 0, 32'(rdy[0]), 1);
      chk("ready_after_reset", 1, 32'(rdy[1]), 1);

      // Reset during the second beat of a STORE len=3.
      wait_idle(50);
      d0 = done_cnt[0];
      send(1'b1, 8'h80, 4'd0, 4'd3);
      @(negedge clk);
      chk("second_beat_addr", 0, 32'(da[0]), 32'h81);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_dwe", 0, 32'(dwe[0]), 0);
      chk("midreset_addr", 0, 32'(da[0]), 0);
      chk("midreset_ready", 0, 32'(rdy[0]), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_midreset", 0, 32'(rdy[0]), 1);
      repeat (6) @(negedge clk);
      chk("no_done_after_reset", 0, 32'(done_cnt[0]), 32'(d0));

      // Single LOAD.
      preload(1'b0, 8'h27, 16'hBEEF);
      wait_idle(50);
      clear_logs();
      send(1'b0, 8'h27, 4'd1, 4'd0);
      wait_idle(50);
      chk("load_rf1", 0, 32'(rf[1]), 32'hBEEF);
      chk("load_cycles", 0, 32'(done_cyc[0] - acc_cyc[0] + 1), 3);
      chk("load_cycles", 1, 32'(done_cyc[1] - acc_cyc[1] + 1), 5);
      chk("load_wr_count", 0, 32'(wlog_d.size()), 1);
      if (wlog_d.size() == 1) begin
         chk("load_wr_daddr", 0, 32'(wlog_d[0]), 32'h27);
         chk("load_wr_rfaddr", 0, 32'(wlog_r[0]), 1);
      end

      // STORE burst R2..R4 -> 0x10..0x12.
      preload(1'b1, 8'd2, 16'h1111);
      preload(1'b1, 8'd3, 16'h2222);
      preload(1'b1, 8'd4, 16'h3333);
      wait_idle(50);
      clear_logs();
      send(1'b1, 8'h10, 4'd2, 4'd2);
      wait_idle(50);
      chk("store_mem10", 0, 32'(mem[8'h10]), 32'h1111);
      chk("store_mem11", 0, 32'(mem[8'h11]), 32'h2222);
      chk("store_mem12", 0, 32'(mem[8'h12]), 32'h3333);
      chk("store_cycles", 0, 32'(done_cyc[0] - acc_cyc[0] + 1), 4);
      chk("store_wr_count", 0, 32'(slog_a.size()), 3);
      if (slog_a.size() == 3) begin
         chk("store_addr0", 0, 32'(slog_a[0]), 32'h10);
         chk("store_addr2", 0, 32'(slog_a[2]), 32'h12);
         chk("store_consecutive", 0, 32'(slog_c[2] - slog_c[0]), 2);
      end

      // Wrap-around LOAD.
      wait_idle(50);
      clear_logs();
      send(1'b0, 8'hFE, 4'd15, 4'd2);
      wait_idle(80);
      chk("wrap_wr_count", 0, 32'(wlog_d.size()), 3);
      if (wlog_d.size() == 3) begin
         chk("wrap_d0", 0, 32'(wlog_d[0]), 32'hFE);
         chk("wrap_d1", 0, 32'(wlog_d[1]), 32'hFF);
         chk("wrap_d2", 0, 32'(wlog_d[2]), 32'h00);
         chk("wrap_r0", 0, 32'(wlog_r[0]), 15);
         chk("wrap_r1", 0, 32'(wlog_r[1]), 0);
         chk("wrap_r2", 0, 32'(wlog_r[2]), 1);
      end
      chk("wrap_cycles", 1, 32'(done_cyc[1] - acc_cyc[1] + 1), 13);

      // RD_LAT=3 LOAD len=1: RF writes in cycles 4 and 8, done in cycle 9.
      wait_idle(50);
      clear_logs();
      send(1'b0, 8'h50, 4'd5, 4'd1);
      wait_idle(80);
      chk("lat3_cycles", 1, 32'(done_cyc[1] - acc_cyc[1] + 1), 9);
      chk("lat3_wb_count", 1, 32'(wb3.size()), 2);
      if (wb3.size() == 2) begin
         chk("lat3_wb0", 1, 32'(wb3[0]), 4);
         chk("lat3_wb1", 1, 32'(wb3[1]), 8);
      end

      // Handshake: valid held while busy with changing fields; next command taken after done.
      wait_idle(50);
      clear_logs();
      @(negedge clk);
      cmd_op = 1'b1; cmd_d_addr = 8'h20; cmd_rf_addr = 4'd6; cmd_len = 4'd2; cmd_valid = 1'b1;
      done_edge = -1;
      for (int n = 0; n < 20 && done_edge < 0; n++) begin
         @(negedge clk);
         if (dn[0]) begin
            done_edge = cyc;
            cmd_op = 1'b0; cmd_d_addr = 8'h40; cmd_rf_addr = 4'd3; cmd_len = 4'd0;
         end else begin
            cmd_op = ~cmd_op; cmd_d_addr = cmd_d_addr + 8'h11; cmd_rf_addr = cmd_rf_addr + 4'd5;
            cmd_len = cmd_len + 4'd3;
         end
      end
      chk("hs_done_seen", 0, 32'(done_edge >= 0), 1);
      @(negedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("hs_accept_edge", 0, 32'(acc_cyc[0] - done_edge), 2);
      wait_idle(80);
      chk("hs_store_count", 0, 32'(slog_a.size()), 3);
      if (slog_a.size() == 3) chk("hs_store_last", 0, 32'(slog_a[2]), 32'h22);
      chk("hs_load_count", 0, 32'(wlog_d.size()), 1);
      if (wlog_d.size() == 1) begin
         chk("hs_load_daddr", 0, 32'(wlog_d[0]), 32'h40);
         chk("hs_load_rfaddr", 0, 32'(wlog_r[0]), 3);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog (cycle %0d): simulation did not finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
